// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture path: default 800x600 mode, capture FSM
// states and helpers that derive line/frame timing from the mode parameters.
package vga_pkg;

    localparam int unsigned DEF_H_VIS_AREA_PXL    = 800;
    localparam int unsigned DEF_H_FRONT_PORCH_PXL = 40;
    localparam int unsigned DEF_H_SYNC_PULSE_PXL  = 128;
    localparam int unsigned DEF_H_BACK_PORCH_PXL  = 88;
    localparam int unsigned DEF_H_NUM_BITS        = 11;
    localparam int unsigned DEF_V_VIS_AREA_PXL    = 600;
    localparam int unsigned DEF_V_FRONT_PORCH_PXL = 1;
    localparam int unsigned DEF_V_SYNC_PULSE_PXL  = 4;
    localparam int unsigned DEF_V_BACK_PORCH_PXL  = 23;
    localparam int unsigned DEF_V_NUM_BITS        = 10;
    localparam int unsigned DEF_CHANNEL_BITS      = 2;
    localparam int unsigned DEF_LOCK_FRAMES       = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } capture_state_t;

    function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start(input int unsigned vis, input int unsigned fp);
        return vis + fp;
    endfunction

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                       input int unsigned hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_capture_axis_track.sv
// One timing axis: position counter with wrap, load-on-sync-edge, and a compare
// of the sampled sync level against the level the position implies.
module vga_axis_track
    import vga_pkg::*;
#(
    parameter int unsigned W          = DEF_H_NUM_BITS,
    parameter int unsigned TOTAL      = 1056,
    parameter int unsigned SYNC_START = 840,
    parameter int unsigned SYNC_END   = 968
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         sync_lvl,
    output logic [W-1:0] pos_c,
    output logic         wrap_c,
    output logic         mismatch_c
);

    logic [W-1:0] pos_q, pos_d;

    // pos_c is the position of the sample currently in stage 1.
    always_comb begin
        pos_c      = load ? load_val : pos_q;
        wrap_c     = step && (32'(pos_c) == TOTAL - 1);
        pos_d      = pos_c;
        if (wrap_c) begin
            pos_d = '0;
        end else if (step) begin
            pos_d = pos_c + W'(1);
        end
        mismatch_c = sync_lvl != !in_window(32'(pos_c), SYNC_START, SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: samples syncs and RGB, recovers pixel coordinates, locks to
// the configured mode and emits a registered visible-pixel write stream.
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS_AREA_PXL    = DEF_H_VIS_AREA_PXL,
    parameter int unsigned H_FRONT_PORCH_PXL = DEF_H_FRONT_PORCH_PXL,
    parameter int unsigned H_SYNC_PULSE_PXL  = DEF_H_SYNC_PULSE_PXL,
    parameter int unsigned H_BACK_PORCH_PXL  = DEF_H_BACK_PORCH_PXL,
    parameter int unsigned H_NUM_BITS        = DEF_H_NUM_BITS,
    parameter int unsigned V_VIS_AREA_PXL    = DEF_V_VIS_AREA_PXL,
    parameter int unsigned V_FRONT_PORCH_PXL = DEF_V_FRONT_PORCH_PXL,
    parameter int unsigned V_SYNC_PULSE_PXL  = DEF_V_SYNC_PULSE_PXL,
    parameter int unsigned V_BACK_PORCH_PXL  = DEF_V_BACK_PORCH_PXL,
    parameter int unsigned V_NUM_BITS        = DEF_V_NUM_BITS,
    parameter int unsigned CHANNEL_BITS      = DEF_CHANNEL_BITS,
    parameter int unsigned LOCK_FRAMES       = DEF_LOCK_FRAMES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      h_sync,
    input  logic                      v_sync,
    input  logic [3:0]                red,
    input  logic [3:0]                green,
    input  logic [3:0]                blue,
    output logic                      pxl_valid,
    output logic [H_NUM_BITS-1:0]     pxl_x,
    output logic [V_NUM_BITS-1:0]     pxl_y,
    output logic [3*CHANNEL_BITS-1:0] pxl_color,
    output logic                      frame_start,
    output logic                      locked,
    output logic                      sync_err
);

    localparam int unsigned H_TOTAL = axis_total(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL,
                                                 H_SYNC_PULSE_PXL, H_BACK_PORCH_PXL);
    localparam int unsigned V_TOTAL = axis_total(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL,
                                                 V_SYNC_PULSE_PXL, V_BACK_PORCH_PXL);
    localparam int unsigned HS0     = sync_start(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL);
    localparam int unsigned HS1     = HS0 + H_SYNC_PULSE_PXL;
    localparam int unsigned VS0     = sync_start(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL);
    localparam int unsigned VS1     = VS0 + V_SYNC_PULSE_PXL;
    localparam int unsigned CW      = 3 * CHANNEL_BITS;
    localparam int unsigned GW      = $clog2(LOCK_FRAMES + 1);

    logic          s_h_q, s_h_d, s_v_q, s_v_d;
    logic          prev_h_q, prev_h_d, prev_v_q, prev_v_d;
    logic [CW-1:0] s_color_q, s_color_d;

    capture_state_t state_q, state_d;
    logic [GW-1:0]  good_cnt_q, good_cnt_d;

    logic                  pxl_valid_q, pxl_valid_d;
    logic [H_NUM_BITS-1:0] pxl_x_q, pxl_x_d;
    logic [V_NUM_BITS-1:0] pxl_y_q, pxl_y_d;
    logic [CW-1:0]         pxl_color_q, pxl_color_d;
    logic                  frame_start_q, frame_start_d;
    logic                  locked_q, locked_d;
    logic                  sync_err_q, sync_err_d;

    logic                  h_fall_c, v_fall_c, search_c;
    logic                  h_load_c, v_load_c;
    logic [H_NUM_BITS-1:0] h_load_val_c, h_pos_c;
    logic [V_NUM_BITS-1:0] v_pos_c;
    logic                  h_wrap_c, v_wrap_unused_c;
    logic                  h_mis_c, v_mis_c;
    logic                  vsync_start_c, vis_c;
    logic                  unused_pin_bits_c;

    // Only the top CHANNEL_BITS of each channel are kept.
    assign unused_pin_bits_c = ^{red, green, blue};

    // Stage 1 sample plus the previous sync levels for edge detection.
    always_comb begin
        s_h_d     = h_sync;
        s_v_d     = v_sync;
        prev_h_d  = s_h_q;
        prev_v_d  = s_v_q;
        s_color_d = {red[3 -: CHANNEL_BITS], green[3 -: CHANNEL_BITS], blue[3 -: CHANNEL_BITS]};
    end

    assign h_fall_c     = prev_h_q && !s_h_q;
    assign v_fall_c     = prev_v_q && !s_v_q;
    assign search_c     = (state_q == SEARCH);
    assign h_load_c     = search_c && (h_fall_c || v_fall_c);
    assign h_load_val_c = v_fall_c ? '0 : H_NUM_BITS'(HS0);
    assign v_load_c     = search_c && v_fall_c;

    vga_axis_track #(
        .W          (H_NUM_BITS),
        .TOTAL      (H_TOTAL),
        .SYNC_START (HS0),
        .SYNC_END   (HS1)
    ) u_h_track (
        .clk        (clk),
        .rst        (rst),
        .step       (1'b1),
        .load       (h_load_c),
        .load_val   (h_load_val_c),
        .sync_lvl   (s_h_q),
        .pos_c      (h_pos_c),
        .wrap_c     (h_wrap_c),
        .mismatch_c (h_mis_c)
    );

    vga_axis_track #(
        .W          (V_NUM_BITS),
        .TOTAL      (V_TOTAL),
        .SYNC_START (VS0),
        .SYNC_END   (VS1)
    ) u_v_track (
        .clk        (clk),
        .rst        (rst),
        .step       (h_wrap_c),
        .load       (v_load_c),
        .load_val   (V_NUM_BITS'(VS0)),
        .sync_lvl   (s_v_q),
        .pos_c      (v_pos_c),
        .wrap_c     (v_wrap_unused_c),
        .mismatch_c (v_mis_c)
    );

    assign vsync_start_c = (h_pos_c == '0) && (32'(v_pos_c) == VS0);

    // Lock FSM: an error always wins over a lock-completing vsync start.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        sync_err_d = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (v_fall_c) begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ACQUIRE, LOCKED: begin
                if (h_mis_c || v_mis_c) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end else if ((state_q == ACQUIRE) && vsync_start_c) begin
                    if (32'(good_cnt_q) + 32'd1 == LOCK_FRAMES) begin
                        state_d = LOCKED;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Stage 2: pixel stream, zeroed outside visible locked samples.
    always_comb begin
        vis_c         = (state_q == LOCKED) && (32'(h_pos_c) < H_VIS_AREA_PXL)
                        && (32'(v_pos_c) < V_VIS_AREA_PXL);
        pxl_valid_d   = vis_c;
        pxl_x_d       = vis_c ? h_pos_c : '0;
        pxl_y_d       = vis_c ? v_pos_c : '0;
        pxl_color_d   = vis_c ? s_color_q : '0;
        frame_start_d = vis_c && (h_pos_c == '0) && (v_pos_c == '0);
        locked_d      = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_h_q         <= 1'b1;
            s_v_q         <= 1'b1;
            prev_h_q      <= 1'b1;
            prev_v_q      <= 1'b1;
            s_color_q     <= '0;
            state_q       <= SEARCH;
            good_cnt_q    <= '0;
            pxl_valid_q   <= 1'b0;
            pxl_x_q       <= '0;
            pxl_y_q       <= '0;
            pxl_color_q   <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            s_h_q         <= s_h_d;
            s_v_q         <= s_v_d;
            prev_h_q      <= prev_h_d;
            prev_v_q      <= prev_v_d;
            s_color_q     <= s_color_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            pxl_valid_q   <= pxl_valid_d;
            pxl_x_q       <= pxl_x_d;
            pxl_y_q       <= pxl_y_d;
            pxl_color_q   <= pxl_color_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign pxl_valid   = pxl_valid_q;
    assign pxl_x       = pxl_x_q;
    assign pxl_y       = pxl_y_q;
    assign pxl_color   = pxl_color_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive side of the team's VGA pixel interface. Samples h_sync, v_sync and 4-bit RGB, recovers pixel coordinates, checks the timing against the configured mode and emits a pixel write stream for a frame-buffer writer or a loopback checker.
- All inputs are synchronous to clk, at one pixel per clock. No CDC inside this block.

Parameters:
- H_VIS_AREA_PXL, 800, visible pixels per line
- H_FRONT_PORCH_PXL, 40, horizontal front porch
- H_SYNC_PULSE_PXL, 128, hsync pulse width
- H_BACK_PORCH_PXL, 88, horizontal back porch
- H_NUM_BITS, 11, width of x and h position
- V_VIS_AREA_PXL, 600, visible lines
- V_FRONT_PORCH_PXL, 1, vertical front porch
- V_SYNC_PULSE_PXL, 4, vsync pulse width in lines
- V_BACK_PORCH_PXL, 23, vertical back porch
- V_NUM_BITS, 10, width of y and v position
- CHANNEL_BITS, 2, bits kept per colour channel (1..4)
- LOCK_FRAMES, 2, consecutive error-free frames required to lock (>=1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- h_sync  in  1  active-low hsync
- v_sync  in  1  active-low vsync
- red  in  4  red channel
- green  in  4  green channel
- blue  in  4  blue channel
- pxl_valid  out  1  captured visible pixel this cycle
- pxl_x  out  H_NUM_BITS  pixel column
- pxl_y  out  V_NUM_BITS  pixel row
- pxl_color  out  3*CHANNEL_BITS  {R,G,B}, each the top CHANNEL_BITS of its channel
- frame_start  out  1  pulse with pixel (0,0)
- locked  out  1  timing locked
- sync_err  out  1  one-cycle pulse on a timing violation

Behaviour:
- Definitions:
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
  - HS0 = H_VIS+H_FP; HS1 = HS0+H_SYNC.
  - VS0 = V_VIS+V_FP; VS1 = VS0+V_SYNC.
- Reset: all outputs are 0; FSM goes to SEARCH; sample registers are cleared with the syncs held at 1 (inactive).
- Stage 1 registers the inputs (s_h, s_v, s_rgb) plus the previous-cycle syncs. h_pos/v_pos describe the stage-1 sample.
- Stage 2 registers the outputs. A pixel on the pins at cycle t appears on pxl_* at t+2.
- Position counters:
  - h_pos wraps H_TOTAL-1 -> 0.
  - v_pos increments when h_pos wraps, and wraps V_TOTAL-1 -> 0.
- FSM states:
  - SEARCH:
    - An s_h falling edge sets h_pos := HS0.
    - An s_v falling edge sets h_pos := 0 and v_pos := VS0, then moves to ACQUIRE with good_cnt := 0.
    - No checks are made and sync_err is never raised.
  - ACQUIRE and LOCKED:
    - Counters free-run with no realignment.
    - Every sample is checked: s_h must equal !(HS0 <= h_pos < HS1), and s_v must equal !(VS0 <= v_pos < VS1).
    - Any mismatch pulses sync_err on the next cycle and goes to SEARCH. locked drops on that same cycle.
  - ACQUIRE: on each expected vsync start (v_pos == VS0, h_pos == 0) with no error, good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked = 1.
- Pixel output:
  - pxl_valid = LOCKED && h_pos < H_VIS && v_pos < V_VIS.
  - frame_start = pxl_valid && x == 0 && y == 0.
  - When pxl_valid = 0, pxl_x, pxl_y and pxl_color hold 0.
- Widths:
  - pxl_color = {red[3:4-CB], green[3:4-CB], blue[3:4-CB]}.
  - Positions are compared zero-extended; no truncation is permitted (H_NUM_BITS >= clog2(H_TOTAL)).
- Simultaneous events:
  - An error on the same sample that would complete lock takes priority: go to SEARCH, no lock.
  - rst overrides everything, mid-frame included.

Decomposition:
- Package vga_pkg holds:
  - timing localparams (H/V totals, HS0/HS1/VS0/VS1), computed from the mode parameters;
  - the FSM enum typedef capture_state_t {SEARCH, ACQUIRE, LOCKED};
  - the shared default 800x600 mode constants.
- One sub-module, vga_axis_track, instantiated twice (h and v): position counter with wrap, load-on-edge, and expected-sync-level compare producing a mismatch flag.

Test Plan:
- Bench mode: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CB=2, LOCK_FRAMES=2, stimulus from the team's generator at the same parameters.
- rst held 5 cycles with random pins -> all outputs 0 throughout; locked=0.
- Clean stream, RGB constant 12'hA5C -> locked rises after the 2nd error-free vsync start following the first vsync; then each frame has 32 pxl_valid cycles, x 0..7, y 0..3, pxl_color=6'b100111, frame_start once per frame coincident with (0,0), pxl_* 2 cycles after pins.
- While locked, shorten one hsync pulse to 2 cycles -> sync_err single pulse at expected-low mismatch +1, locked=0, pxl_valid=0 until relock 2 frames later.
- While locked, insert an extra back-porch line (V_TOTAL 9) -> sync_err at the first line where v_sync level disagrees; FSM to SEARCH; relocks on the corrected stream.
- rst asserted mid-frame while locked -> next cycle locked=0, pxl_valid=0; after release, relock needs 1 vsync plus 2 clean frames.
- hsync glitches (1-cycle lows) while in SEARCH before any vsync -> sync_err never asserted, locked stays 0.
